fdiv_iter: RTL and testbench

//  IEEE-754 floating-point divider (out = a / b); the counterpart of the fmul datapath in the FP unit.

---
 rtl/fdiv_iter_if.sv | 19 +
 rtl/fdiv_iter.sv | 170 +++++++++++++++++
 tb/tb_fdiv_iter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fdiv_iter_if.sv
// fdiv_iter_if: operand/result handshake bundle for the iterative FP divider.
//   start  : operand strobe (master -> slave)
//   a, b   : dividend and divisor (master -> slave)
//   ready  : divider idle and able to accept start (slave -> master)
//   valid  : one-cycle pulse marking a new result on out (slave -> master)
//   out    : quotient, held until the next result (slave -> master)
interface fdiv_iter_if #(parameter int N = 32);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ready;
  logic         valid;
  logic [N-1:0] out;

  modport master (output start, output a, output b,
                  input ready, input valid, input out);
  modport slave  (input start, input a, input b,
                  output ready, output valid, output out);
endinterface

// File: rtl/fdiv_iter.sv
// fdiv_iter: IEEE-754 divider (out = a / b), restoring, one quotient bit per clock.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset; aborts any division in flight
//   bus  : fdiv_iter_if slave (start/a/b in, ready/valid/out out)
// Fixed latency: IDLE -> DIV (ITER cycles) -> NORM -> DONE -> IDLE. Special
// operands run through the same sequence and their result overrides in NORM.
// Rounding is truncation; denormal inputs read as zero, underflow flushes to zero.
module fdiv_iter #(
  parameter int N = 32
) (
  input  logic clk,
  input  logic rst,
  fdiv_iter_if.slave bus
);
  localparam int E    = (N == 64) ? 11 : 8;
  localparam int M    = N - 1 - E;
  localparam int BIAS = (1 << (E - 1)) - 1;
  localparam int ITER = M + 2;
  localparam int CW   = $clog2(ITER);
  localparam int RW   = M + 2;

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;
  typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} spec_t;

  state_t          state_r;
  spec_t           spec_r;
  spec_t           spec_s;
  logic            sign_r;
  logic [E-1:0]    ea_r, eb_r;
  logic [RW-1:0]   rem_r;
  logic [M:0]      div_r;
  logic [ITER-1:0] q_r;
  logic [CW-1:0]   cnt_r;
  logic            ready_r, valid_r;
  logic [N-1:0]    out_r;

  logic [E-1:0]    ea_s, eb_s;
  logic            a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic            ge_s;
  logic [RW-1:0]   rem_sub_s;
  logic [M-1:0]    frac_s;
  logic signed [E+1:0] e_s;
  logic [N-1:0]    res_s;

  localparam logic signed [E+1:0] EMAX = (E+2)'((1 << E) - 1);

  assign bus.ready = ready_r;
  assign bus.valid = valid_r;
  assign bus.out   = out_r;

  // Classify incoming operands; exponent 0 means zero (denormals included).
  always_comb begin
    ea_s     = bus.a[N-2:M];
    eb_s     = bus.b[N-2:M];
    a_zero_s = (ea_s == '0);
    b_zero_s = (eb_s == '0);
    a_inf_s  = (ea_s == '1) && (bus.a[M-1:0] == '0);
    b_inf_s  = (eb_s == '1) && (bus.b[M-1:0] == '0);
    a_nan_s  = (ea_s == '1) && (bus.a[M-1:0] != '0);
    b_nan_s  = (eb_s == '1) && (bus.b[M-1:0] != '0);
    if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
      spec_s = SP_NAN;
    end else if (a_inf_s || b_zero_s) begin
      spec_s = SP_INF;
    end else if (a_zero_s || b_inf_s) begin
      spec_s = SP_ZERO;
    end else begin
      spec_s = SP_NONE;
    end
  end

  // One restoring step: subtract the divisor when the remainder covers it.
  always_comb begin
    ge_s      = (rem_r >= {1'b0, div_r});
    if (ge_s) begin
      rem_sub_s = rem_r - {1'b0, div_r};
    end else begin
      rem_sub_s = rem_r;
    end
  end

  // Normalise the quotient (in (0.5,2)) and assemble the final encoding.
  always_comb begin
    if (q_r[ITER-1]) begin
      frac_s = q_r[ITER-2:1];
      e_s    = {2'b00, ea_r} - {2'b00, eb_r} + (E+2)'(BIAS);
    end else begin
      frac_s = q_r[ITER-3:0];
      e_s    = {2'b00, ea_r} - {2'b00, eb_r} + (E+2)'(BIAS) - (E+2)'(1);
    end
    case (spec_r)
      SP_NAN:  res_s = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
      SP_INF:  res_s = {sign_r, {E{1'b1}}, {M{1'b0}}};
      SP_ZERO: res_s = {sign_r, {(N-1){1'b0}}};
      default: begin
        if (e_s >= EMAX) begin
          res_s = {sign_r, {E{1'b1}}, {M{1'b0}}};
        end else if (e_s[E+1] || (e_s == '0)) begin
          res_s = {sign_r, {(N-1){1'b0}}};
        end else begin
          res_s = {sign_r, e_s[E-1:0], frac_s};
        end
      end
    endcase
  end

  // Control FSM and datapath registers, outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      spec_r  <= SP_NONE;
      sign_r  <= 1'b0;
      ea_r    <= '0;
      eb_r    <= '0;
      rem_r   <= '0;
      div_r   <= '0;
      q_r     <= '0;
      cnt_r   <= '0;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
      out_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          valid_r <= 1'b0;
          if (bus.start && ready_r) begin
            sign_r  <= bus.a[N-1] ^ bus.b[N-1];
            spec_r  <= spec_s;
            ea_r    <= ea_s;
            eb_r    <= eb_s;
            rem_r   <= {1'b0, 1'b1, bus.a[M-1:0]};
            div_r   <= {1'b1, bus.b[M-1:0]};
            q_r     <= '0;
            cnt_r   <= '0;
            ready_r <= 1'b0;
            state_r <= DIV;
          end else begin
            ready_r <= 1'b1;
          end
        end
        DIV: begin
          rem_r <= {rem_sub_s[RW-2:0], 1'b0};
          q_r   <= {q_r[ITER-2:0], ge_s};
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == CW'(ITER - 1)) begin
            state_r <= NORM;
          end else begin
            state_r <= DIV;
          end
        end
        NORM: begin
          // Result and valid land together so DONE presents them for one cycle.
          out_r   <= res_s;
          valid_r <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          valid_r <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          valid_r <= 1'b0;
          ready_r <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fdiv_iter.sv
// tb_fdiv_iter: directed self-checking bench for fdiv_iter (single precision).
module tb_fdiv_iter;
  localparam int N    = 32;
  localparam int ITER = 25;
  // Edges after the accepting edge until valid is seen (DIV x ITER, NORM).
  localparam int LAT  = ITER + 1;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fdiv_iter_if #(.N(N)) bus ();

  fdiv_iter #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Issue one operation and wait (bounded) for its result.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_v, input string tag);
    int n;
    @(negedge clk);
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({tag, "_busy"}, {31'd0, bus.ready}, 32'd0);
    n = 1;
    @(posedge clk);
    #1;
    while (!bus.valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, n, LAT);
    check({tag, "_out"}, bus.out, exp_v);
    @(posedge clk);
    #1;
    check({tag, "_vpulse"}, {31'd0, bus.valid}, 32'd0);
    check({tag, "_ready"}, {31'd0, bus.ready}, 32'd1);
    check({tag, "_hold"}, bus.out, exp_v);
  endtask

  initial begin
    int vcount;
    int n;
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.a     = 32'd0;
    bus.b     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_valid", {31'd0, bus.valid}, 32'd0);
    check("rst_out", bus.out, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op(32'h40C00000, 32'h40000000, 32'h40400000, "six_by_two");
    run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, "one_third");
    run_op(32'hC1200000, 32'h40A00000, 32'hC0000000, "neg_ten_by_five");
    run_op(32'hBF800000, 32'h00000000, 32'hFF800000, "div_by_zero");
    run_op(32'h00000000, 32'h00000000, 32'h7FC00000, "zero_zero");
    run_op(32'h7F800000, 32'h7F800000, 32'h7FC00000, "inf_inf");
    run_op(32'h3F800000, 32'h7F800000, 32'h00000000, "by_inf");
    run_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan_in");
    run_op(32'h7F000000, 32'h00800000, 32'h7F800000, "overflow");
    run_op(32'h00800000, 32'h7F000000, 32'h00000000, "underflow");

    // start pulsed while busy must be ignored.
    @(negedge clk);
    bus.a     = 32'h40C00000;
    bus.b     = 32'h40000000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.a     = 32'h3F800000;
    bus.b     = 32'h40400000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.valid) begin
        vcount++;
        check("busy_start_out", bus.out, 32'h40400000);
      end
    end
    check("busy_start_pulses", vcount, 1);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    bus.a     = 32'h3F800000;
    bus.b     = 32'h40400000;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("abort_ready", {31'd0, bus.ready}, 32'd1);
    check("abort_valid", {31'd0, bus.valid}, 32'd0);
    check("abort_out", bus.out, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.valid) n++;
    end
    check("abort_no_valid", n, 0);
    run_op(32'h40C00000, 32'h40000000, 32'h40400000, "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
